rst_req_ctl: RTL and testbench
==============================

// Module: rst_req_ctl
// PURPOSE
//  Produces the active-low external reset request that feeds the clock/reset generator's rst_in_n input.
//  Sources: software reset (bus write) and a watchdog timeout.
//  Bus slave on the I/O bus; records the cause of the last requested reset for boot firmware.
// PARAMETERS
//  PULSE_LEN   16       cycles rst_req_n is held low per request (>=4; generator needs >=3 to sample)
//  PRESCALE    50000    clk cycles per watchdog tick (1 ms @ 50 MHz); >=2
//  WARN_TICKS  256      ticks before timeout at which warn irq fires (only with RST_REQ_WARN_IRQ_EN)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-high reset (from clock/reset generator)
//  stb       in   1   bus strobe, access valid this cycle
//  we        in   1   1=write, 0=read
//  addr      in   2   word address (byte addr bits 3:2)
//  data_in   in   32  write data
//  data_out  out  32  read data, combinational from addr
//  wt        out  1   bus wait; always 0 (single-cycle access)
//  rst_req_n out  1   reset request to generator, active low
//  irq       out  1   watchdog early-warning interrupt (0 when feature compiled out)
// BEHAVIOUR
//  Registers (addr): 0 CTRL  rw  bit0 WDE (watchdog enable); bit1 SWR (write 1 = sw reset, reads 0)
//                    1 LOAD  rw  32-bit timeout in ticks; reset value 0xFFFFFFFF
//                    2 KICK  wo  writing 0x0000A5C3 reloads counter; other values ignored; reads 0
//                    3 CAUSE rw1c bit0 SW, bit1 WD, bit2 WARN-pending (irq source); write 1 clears bit
//  Reset values: CTRL=0, cnt=LOAD, prescaler=0, FSM=IDLE, rst_req_n=1, irq=0, wt=0.
//  CAUSE bits 0/1 are NOT cleared by rst (must survive the requested reset); initialised to 0 at
//  configuration; cleared only by rw1c write. CAUSE bit2 is cleared by rst.
//  Watchdog: prescaler counts 0..PRESCALE-1, tick on wrap; only runs while WDE=1.
//   cnt: 32-bit down counter; reloaded from LOAD on WDE 0->1, on valid KICK, and on a LOAD write.
//   On tick with cnt>1: cnt-1. On tick with cnt==1 (or LOAD==0 at enable): timeout -> request WD.
//   WDE=0: cnt and prescaler frozen, no timeouts.
//  FSM: IDLE -> ASSERT on SWR write or WD timeout; sets CAUSE.SW/WD at that edge.
//   ASSERT: rst_req_n=0, pulse counter counts PULSE_LEN cycles -> IDLE, rst_req_n=1 next cycle.
//   rst asserting during ASSERT returns FSM to IDLE (generator already latched the request).
//   Requests while in ASSERT ignored (no cause update).
//  Simultaneous: SWR write and WD timeout same cycle -> both CAUSE bits set, one pulse.
//   KICK in the same cycle as the timeout tick wins: reload, no request.
//   Bus write to CTRL in same cycle as tick uses new WDE from next cycle.
//  Latency: SWR write at cycle N -> rst_req_n low from N+1 (registered output).
// CONFIGURATION
//  RST_REQ_WARN_IRQ_EN defined: when WDE=1 and cnt reaches WARN_TICKS on a tick, set CAUSE.bit2;
//   irq = CAUSE.bit2 (registered); cleared by writing 1 to CAUSE bit2, by KICK, or by rst.
//  Not defined: no warn logic, CAUSE bit2 reads 0, irq tied 0; WARN_TICKS unused.
// STRUCTURE
//  Shared package rst_req_pkg: register offsets, KICK magic 0x0000A5C3, CAUSE bit indices,
//   FSM state encoding (IDLE, ASSERT).
//  One sub-module: rst_req_tick (prescaler, PRESCALE param, en in, tick out one-cycle pulse).
// TESTING
//  1 Write CTRL=0x2 -> rst_req_n low next cycle for exactly 16 cycles; CAUSE reads 0x1; CTRL reads 0.
//  2 PRESCALE=4, LOAD=3, CTRL=1, no kick -> rst_req_n falls 12 cycles after enable; CAUSE=0x2.
//  3 Same as 2 but KICK 0xA5C3 every 8 cycles -> no request for 1000 cycles; KICK 0x1234 -> ignored, timeout.
//  4 Assert rst 3 cycles into ASSERT -> rst_req_n=1 next cycle, CAUSE bits 0/1 retained, CTRL=0.
//  5 SWR write coincident with WD timeout -> single pulse, CAUSE=0x3; write 0x3 to CAUSE -> 0.
//  6 With RST_REQ_WARN_IRQ_EN, WARN_TICKS=2, LOAD=5 -> irq rises after 3rd tick; KICK clears irq.

Source files
------------

// File: rtl/rst_req_pkg.sv
// Shared definitions for the reset-request controller: register map, KICK magic,
// CAUSE bit layout, FSM encoding and the bus request bundle.
package rst_req_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_LOAD  = 2'd1;
  localparam logic [1:0] ADDR_KICK  = 2'd2;
  localparam logic [1:0] ADDR_CAUSE = 2'd3;

  localparam logic [31:0] KICK_MAGIC = 32'h0000_A5C3;

  localparam int CTRL_WDE   = 0;
  localparam int CTRL_SWR   = 1;

  localparam int CAUSE_SW   = 0;
  localparam int CAUSE_WD   = 1;
  localparam int CAUSE_WARN = 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ASSERT = 1'b1;

  typedef struct packed {
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
  } bus_req_t;

endpackage

// File: rtl/rst_req_tick.sv
// Watchdog prescaler: counts 0..PRESCALE-1 while en is high and emits a
// one-cycle tick on the wrap; holds its count while en is low.
module rst_req_tick #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] presc_q;

  assign tick = en && (presc_q == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst)     presc_q <= '0;
    else if (en) presc_q <= tick ? '0 : presc_q + PW'(1);
  end

endmodule

// File: rtl/rst_req_ctl.sv
// Reset-request controller: software/watchdog sources drive an active-low pulse
// to the reset generator. Optional early-warning irq under RST_REQ_WARN_IRQ_EN.
module rst_req_ctl
  import rst_req_pkg::*;
#(
  parameter int PULSE_LEN  = 16,
  parameter int PRESCALE   = 50000,
  parameter int WARN_TICKS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        wt,
  output logic        rst_req_n,
  output logic        irq
);

  localparam int PCW = $clog2(PULSE_LEN);

  bus_req_t       req;
  logic           wde_q;
  logic [31:0]    load_q, cnt_q;
  logic [0:0]     state_q;
  logic [PCW-1:0] pcnt_q;
  // Cause of the last request must outlive the reset it triggers, so no rst term.
  logic [1:0]     cause_q = 2'b00;

  logic tick, wr_ctrl, wr_load, wr_kick, wr_cause, kick_ok, wde_rise, reload;
  logic wd_timeout, req_sw, start;

  assign req      = '{stb: stb, we: we, addr: addr, data: data_in};
  assign wr_ctrl  = req.stb && req.we && (req.addr == ADDR_CTRL);
  assign wr_load  = req.stb && req.we && (req.addr == ADDR_LOAD);
  assign wr_kick  = req.stb && req.we && (req.addr == ADDR_KICK);
  assign wr_cause = req.stb && req.we && (req.addr == ADDR_CAUSE);
  assign kick_ok  = wr_kick && (req.data == KICK_MAGIC);
  assign wde_rise = wr_ctrl && req.data[CTRL_WDE] && !wde_q;
  assign reload   = wr_load || kick_ok || wde_rise;

  // A reload in the same cycle as the final tick cancels the timeout.
  assign wd_timeout = tick && !reload && (cnt_q <= 32'd1);
  assign req_sw     = wr_ctrl && req.data[CTRL_SWR];
  assign start      = (state_q == ST_IDLE) && (req_sw || wd_timeout);

  rst_req_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (wde_q),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wde_q   <= 1'b0;
      load_q  <= '1;
      cnt_q   <= '1;
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
    end else begin
      if (wr_ctrl) wde_q  <= req.data[CTRL_WDE];
      if (wr_load) load_q <= req.data;

      if (wr_load)                    cnt_q <= req.data;
      else if (kick_ok || wde_rise)   cnt_q <= load_q;
      else if (wd_timeout)            cnt_q <= load_q;
      else if (tick)                  cnt_q <= cnt_q - 32'd1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ASSERT;
            pcnt_q  <= '0;
          end
        end
        default: begin
          if (pcnt_q == PCW'(PULSE_LEN - 1)) state_q <= ST_IDLE;
          else                               pcnt_q  <= pcnt_q + PCW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cause_q <= (cause_q & ~(wr_cause ? req.data[CAUSE_WD:CAUSE_SW] : 2'b00))
               | (start ? {wd_timeout, req_sw} : 2'b00);
  end

`ifdef RST_REQ_WARN_IRQ_EN
  logic warn_q, warn_hit;

  assign warn_hit = tick && !reload && (cnt_q > 32'd1)
                 && ((cnt_q - 32'd1) == 32'(WARN_TICKS));

  always_ff @(posedge clk) begin
    if (rst || kick_ok)                          warn_q <= 1'b0;
    else if (warn_hit)                           warn_q <= 1'b1;
    else if (wr_cause && req.data[CAUSE_WARN])   warn_q <= 1'b0;
  end
`else
  logic warn_q;
  assign warn_q = 1'b0;
`endif

  always_comb begin
    data_out = '0;
    case (addr)
      ADDR_CTRL:  data_out[CTRL_WDE] = wde_q;
      ADDR_LOAD:  data_out = load_q;
      ADDR_CAUSE: data_out[CAUSE_WARN:CAUSE_SW] = {warn_q, cause_q};
      default:    ;
    endcase
  end

  assign wt        = 1'b0;
  assign irq       = warn_q;
  assign rst_req_n = (state_q != ST_ASSERT);

endmodule

// File: tb/tb_rst_req_ctl.sv
// Directed bench for rst_req_ctl (PRESCALE=4, PULSE_LEN=16, WARN_TICKS=2).
module tb_rst_req_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        wt, rst_req_n, irq;

  int errs = 0;
  int checks = 0;
  int low_cnt = 0;

  rst_req_ctl #(.PULSE_LEN(16), .PRESCALE(4), .WARN_TICKS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .stb       (stb),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .wt        (wt),
    .rst_req_n (rst_req_n),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst_req_n) low_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk); stb = 1'b0; we = 1'b0; data_in = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1 d = data_out;
  endtask

  task automatic do_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Counts cycles rst_req_n stays low from the current negedge (bounded).
  task automatic pulse_len(output int n);
    n = 0;
    while (!rst_req_n && n < 40) begin @(negedge clk); n++; end
  endtask

  // Counts cycles until rst_req_n falls (bounded).
  task automatic time_to_fall(output int n);
    n = 0;
    while (rst_req_n && n < 100) begin @(negedge clk); n++; end
  endtask

  initial begin
    logic [31:0] d;
    int n, lc0;
    logic fell;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rst_req_n", 32'(rst_req_n), 32'd1);
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset wt", 32'(wt), 32'd0);
    rd(2'd0, d); chk("reset CTRL", d, 32'h0);
    rd(2'd1, d); chk("reset LOAD", d, 32'hFFFF_FFFF);
    rd(2'd3, d); chk("reset CAUSE", d, 32'h0);

    // 1: software reset
    wr(2'd0, 32'h2);
    chk("swr low next cycle", 32'(rst_req_n), 32'd0);
    rd(2'd3, d); chk("swr CAUSE", d, 32'h1);
    rd(2'd0, d); chk("swr CTRL reads 0", d, 32'h0);
    pulse_len(n); chk("swr pulse length", 32'(n), 32'd16);

    // 2: watchdog timeout with no kick
    wr(2'd3, 32'h3);
    do_rst();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    time_to_fall(n); chk("wd fall delay", 32'(n), 32'd12);
    rd(2'd3, d); chk("wd CAUSE", d, 32'h2);
    wr(2'd0, 32'h0);
    repeat (20) @(negedge clk);

    // 3: regular valid kicks hold off the watchdog, bad magic does not
    wr(2'd3, 32'h3);
    do_rst();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    lc0 = low_cnt;
    for (int i = 0; i < 125; i++) begin
      wr(2'd2, 32'h0000_A5C3);
      repeat (6) @(negedge clk);
    end
    chk("kicked no request", 32'(low_cnt - lc0), 32'd0);
    fell = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(2'd2, 32'h0000_1234);
      repeat (6) @(negedge clk);
      if (low_cnt != lc0) fell = 1'b1;
    end
    chk("bad kick ignored", 32'(fell), 32'd1);
    rd(2'd3, d); chk("bad kick CAUSE", d, 32'h2);
    wr(2'd0, 32'h0);
    repeat (20) @(negedge clk);

    // 4: rst during ASSERT
    wr(2'd3, 32'h3);
    do_rst();
    wr(2'd0, 32'h3);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst ends pulse", 32'(rst_req_n), 32'd1);
    rd(2'd3, d); chk("rst keeps CAUSE", d, 32'h1);
    rd(2'd0, d); chk("rst clears CTRL", d, 32'h0);
    rd(2'd1, d); chk("rst restores LOAD", d, 32'hFFFF_FFFF);

    // 5: SWR coincident with watchdog timeout
    wr(2'd3, 32'h3);
    do_rst();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    repeat (10) @(negedge clk);
    wr(2'd0, 32'h3);
    rd(2'd3, d); chk("coincident CAUSE", d, 32'h3);
    pulse_len(n); chk("coincident single pulse", 32'(n), 32'd16);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h3);
    rd(2'd3, d); chk("rw1c clears CAUSE", d, 32'h0);

    // 6: early-warning interrupt
    do_rst();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
`ifdef RST_REQ_WARN_IRQ_EN
    repeat (11) @(negedge clk);
    chk("irq before 3rd tick", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq after 3rd tick", 32'(irq), 32'd1);
    rd(2'd3, d); chk("warn CAUSE", d, 32'h4);
    wr(2'd2, 32'h0000_A5C3);
    chk("kick clears irq", 32'(irq), 32'd0);
`else
    repeat (13) @(negedge clk);
    chk("irq tied low", 32'(irq), 32'd0);
    rd(2'd3, d); chk("no warn CAUSE", d, 32'h0);
`endif
    wr(2'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
